scan_chain_controller: RTL and testbench



---
 rtl/scan_chain_controller_if.sv | 19 +
 rtl/scan_chain_controller.sv | 156 +++++++++++++++
 tb/tb_scan_chain_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_controller_if.sv
// rtl/scan_chain_controller_if.sv - host byte stream handshake between host and scan chain controller
interface scan_chain_controller_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/scan_chain_controller.sv
// rtl/scan_chain_controller.sv - byte-wise scan chain shifter between a host stream and a microcontroller chain
module scan_chain_controller #(
  parameter int CHAIN_LEN = 2096,
  parameter int CNT_W     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    run,
  scan_chain_controller_if.slave  host,
  output logic                    scan_enable,
  output logic                    scan_in,
  input  logic                    scan_out,
  output logic                    proc_en,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, EMIT, FINISH} state_t;

  localparam logic [CNT_W-1:0] LEN       = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

  state_t           state_q, state_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [3:0]       left_q, left_d;
  logic [3:0]       n_q, n_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             scan_enable_q, scan_enable_d;
  logic             scan_in_q, scan_in_d;
  logic             proc_en_q, proc_en_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] remaining;
  logic [3:0]       n_next;
  logic [7:0]       cap_next;

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    bits_d     = bits_q;
    left_d     = left_q;
    n_d        = n_q;
    shift_d    = shift_q;
    cap_d      = cap_q;
    out_data_d = out_data_q;
    proc_en_d  = proc_en_q;

    remaining = LEN - bits_q;
    n_next    = (remaining >= BYTE_BITS) ? 4'd8 : remaining[3:0];
    cap_next  = {scan_out, cap_q[7:1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          run_d     = run;
          bits_d    = '0;
          proc_en_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (host.in_valid) begin
          shift_d = host.in_data;
          cap_d   = '0;
          n_d     = n_next;
          left_d  = n_next;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        cap_d   = cap_next;
        bits_d  = (bits_q == LEN) ? bits_q : bits_q + CNT_W'(1);
        left_d  = left_q - 4'd1;
        if (left_q == 4'd1) begin
          // A short final byte sits in the top bits; realign so bit 0 is the first bit out.
          out_data_d = cap_next >> (4'd8 - n_q);
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (host.out_ready) begin
          if (bits_q == LEN) begin
            proc_en_d = run_q;
            state_d   = FINISH;
          end else begin
            state_d = LOAD;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    scan_enable_d = (state_d == SHIFT);
    scan_in_d     = (state_d == SHIFT) ? shift_d[0] : 1'b0;
    in_ready_d    = (state_d == LOAD);
    out_valid_d   = (state_d == EMIT);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      run_q         <= 1'b0;
      bits_q        <= '0;
      left_q        <= '0;
      n_q           <= '0;
      shift_q       <= '0;
      cap_q         <= '0;
      out_data_q    <= '0;
      scan_enable_q <= 1'b0;
      scan_in_q     <= 1'b0;
      proc_en_q     <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      bits_q        <= bits_d;
      left_q        <= left_d;
      n_q           <= n_d;
      shift_q       <= shift_d;
      cap_q         <= cap_d;
      out_data_q    <= out_data_d;
      scan_enable_q <= scan_enable_d;
      scan_in_q     <= scan_in_d;
      proc_en_q     <= proc_en_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign host.in_ready  = in_ready_q;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign scan_enable    = scan_enable_q;
  assign scan_in        = scan_in_q;
  assign proc_en        = proc_en_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_scan_chain_controller.sv
// tb/tb_scan_chain_controller.sv - directed scoreboard bench with loopback chain models for 12- and 8-bit chains
module tb_scan_chain_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, run_a, scan_out_a, se_a, si_a, pe_a, busy_a, done_a;
  logic start_b, run_b, scan_out_b, se_b, si_b, pe_b, busy_b, done_b;

  scan_chain_controller_if ifa ();
  scan_chain_controller_if ifb ();

  scan_chain_controller #(.CHAIN_LEN(12), .CNT_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .run(run_a), .host(ifa),
    .scan_enable(se_a), .scan_in(si_a), .scan_out(scan_out_a),
    .proc_en(pe_a), .busy(busy_a), .done(done_a)
  );

  scan_chain_controller #(.CHAIN_LEN(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .run(run_b), .host(ifb),
    .scan_enable(se_b), .scan_in(si_b), .scan_out(scan_out_b),
    .proc_en(pe_b), .busy(busy_b), .done(done_b)
  );

  // Loopback chain models: scan_in enters at the top, scan_out leaves from bit 0.
  logic [11:0] chain_a = '0;
  logic [7:0]  chain_b = '0;
  logic        load_a = 1'b0, load_b = 1'b0;
  logic [11:0] pre_a = '0;
  logic [7:0]  pre_b = '0;
  int se_cnt_a = 0, se_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;

  assign scan_out_a = chain_a[0];
  assign scan_out_b = chain_b[0];

  always @(posedge clk) begin
    if (load_a) chain_a <= pre_a;
    else if (se_a) chain_a <= {si_a, chain_a[11:1]};
    if (load_b) chain_b <= pre_b;
    else if (se_b) chain_b <= {si_b, chain_b[7:1]};
    if (se_a) se_cnt_a <= se_cnt_a + 1;
    if (se_b) se_cnt_b <= se_cnt_b + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit s, input logic r);
    if (s) begin start_b = 1'b1; run_b = r; end
    else begin start_a = 1'b1; run_a = r; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_byte(input bit s, input logic [7:0] b);
    int k = 0;
    while (!(s ? ifb.in_ready : ifa.in_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", s ? ifb.in_ready : ifa.in_ready, 1);
    if (s) begin ifb.in_data = b; ifb.in_valid = 1'b1; end
    else begin ifa.in_data = b; ifa.in_valid = 1'b1; end
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  task automatic recv_byte(input bit s, input int stall);
    int k = 0;
    int se0;
    logic [11:0] ch0;
    logic [7:0] od0;
    logic [7:0] exp;
    while (!(s ? ifb.out_valid : ifa.out_valid) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("out_valid_wait", s ? ifb.out_valid : ifa.out_valid, 1);
    check("in_ready_excl", s ? ifb.in_ready : ifa.in_ready, 0);
    if (stall > 0) begin
      se0 = s ? se_cnt_b : se_cnt_a;
      ch0 = s ? {4'b0, chain_b} : chain_a;
      od0 = s ? ifb.out_data : ifa.out_data;
      repeat (stall) @(negedge clk);
      check("stall_se_cnt", s ? se_cnt_b : se_cnt_a, se0);
      check("stall_chain", s ? {4'b0, chain_b} : chain_a, ch0);
      check("stall_out_data", s ? ifb.out_data : ifa.out_data, od0);
      check("stall_out_valid", s ? ifb.out_valid : ifa.out_valid, 1);
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty_pop", 1, 0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check("out_data", s ? ifb.out_data : ifa.out_data, exp);
    if (s) ifb.out_ready = 1'b1; else ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
  endtask

  task automatic wait_idle(input bit s);
    int k = 0;
    while ((s ? busy_b : busy_a) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", s ? busy_b : busy_a, 0);
  endtask

  initial begin
    int s0, d0;
    logic [11:0] ch0;
    rst_n = 1'b0;
    start_a = 1'b0; run_a = 1'b0; start_b = 1'b0; run_b = 1'b0;
    ifa.in_data = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_data = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs_a", {busy_a, ifa.in_ready, ifa.out_valid, se_a, si_a, pe_a, done_a}, 0);
    check("rst_out_data_a", ifa.out_data, 0);
    check("rst_outs_b", {busy_b, ifb.in_ready, ifb.out_valid, se_b, si_b, pe_b, done_b}, 0);
    rst_n = 1'b1;
    pre_a = 12'hF0F; load_a = 1'b1;
    pre_b = 8'h3C;   load_b = 1'b1;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0;

    // 12-bit chain, two bytes, run=1, stalled first EMIT
    s0 = se_cnt_a; d0 = done_cnt_a;
    pulse_start(1'b0, 1'b1);
    check("a_busy_after_start", busy_a, 1);
    exp_q.push_back(8'h0F);
    send_byte(1'b0, 8'hA5);
    recv_byte(1'b0, 10);
    exp_q.push_back(8'h0F);
    send_byte(1'b0, 8'h03);
    recv_byte(1'b0, 0);
    check("a_done_high", done_a, 1);
    check("a_proc_en_finish", pe_a, 1);
    wait_idle(1'b0);
    check("a_done_once", done_cnt_a - d0, 1);
    check("a_shift_cycles", se_cnt_a - s0, 12);
    check("a_chain", chain_a, 12'h3A5);
    check("a_proc_en_hold", pe_a, 1);

    // 8-bit chain, run=1
    pulse_start(1'b1, 1'b1);
    exp_q.push_back(8'h3C);
    send_byte(1'b1, 8'h5A);
    recv_byte(1'b1, 0);
    wait_idle(1'b1);
    check("b1_proc_en", pe_b, 1);
    check("b1_chain", chain_b, 8'h5A);

    // 8-bit chain, run=0, byte 0xFF, start pulsed during SHIFT
    s0 = se_cnt_b; d0 = done_cnt_b;
    pulse_start(1'b1, 1'b0);
    check("b2_proc_en_cleared", pe_b, 0);
    exp_q.push_back(8'h5A);
    send_byte(1'b1, 8'hFF);
    check("b2_in_shift", se_b, 1);
    pulse_start(1'b1, 1'b1);
    recv_byte(1'b1, 0);
    wait_idle(1'b1);
    check("b2_shift_cycles", se_cnt_b - s0, 8);
    check("b2_done_once", done_cnt_b - d0, 1);
    check("b2_proc_en", pe_b, 0);
    check("b2_chain", chain_b, 8'hFF);

    // Reset during the third SHIFT cycle of the 12-bit chain
    pulse_start(1'b0, 1'b1);
    send_byte(1'b0, 8'h11);
    check("r_shift1", se_a, 1);
    s0 = se_cnt_a;
    @(negedge clk);
    @(negedge clk);
    check("r_shift3", se_a, 1);
    rst_n = 1'b0;
    #1;
    check("r_se_async", se_a, 0);
    check("r_busy_async", busy_a, 0);
    ch0 = chain_a;
    @(negedge clk);
    check("r_shift_count", se_cnt_a - s0, 2);
    check("r_chain_frozen", chain_a, ch0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("r_idle_outs", {busy_a, ifa.in_ready, ifa.out_valid, se_a, pe_a, done_a}, 0);
    pulse_start(1'b0, 1'b0);
    check("r_restart_load", ifa.in_ready, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
